bsg_profiler_counter_bank: RTL and testbench



---
 rtl/bsg_profiler_counter_bank.sv | 130 +++++++++++++
 tb/tb_bsg_profiler_counter_bank.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_profiler_counter_bank.sv
// Bank of saturating per-event counters with snapshot-and-stream dump.
// Latency: first entry valid the cycle after dump_v_i, one entry per cycle while ready_i is high.
// Backpressure: entries hold while v_o & ~ready_i; a dump that arrives mid-stream is dropped and overrun_o pulses.
module bsg_profiler_counter_bank #(
    parameter int els_p           = 8,
    parameter int width_p         = 32,
    parameter bit clear_on_dump_p = 1'b1,
    localparam int lg_els_lp      = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [els_p-1:0]     countme_i,
    input  logic                 dump_v_i,
    output logic                 v_o,
    input  logic                 ready_i,
    output logic [lg_els_lp-1:0] id_o,
    output logic [width_p-1:0]   count_o,
    output logic                 last_o,
    output logic                 busy_o,
    output logic                 overrun_o
);

    typedef enum logic {IDLE, STREAM} state_e;

    localparam logic [width_p-1:0]   max_count_lp = {width_p{1'b1}};
    localparam logic [lg_els_lp-1:0] last_idx_lp  = lg_els_lp'(els_p - 1);

    state_e                 state_r, state_n;
    logic [lg_els_lp-1:0]   index_r;
    logic [width_p-1:0]     live_r   [els_p];
    logic [width_p-1:0]     shadow_r [els_p];

    logic dump_accept;
    logic handshake;
    logic overrun;
    logic at_last;

    assign at_last = (index_r == last_idx_lp);

    // State register; reset abandons any stream in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next state and per-cycle strobes: accept a dump only when idle, advance on handshake.
    always_comb begin
        state_n     = state_r;
        dump_accept = 1'b0;
        handshake   = 1'b0;
        overrun     = 1'b0;
        case (state_r)
            IDLE: begin
                if (dump_v_i) begin
                    dump_accept = 1'b1;
                    state_n     = STREAM;
                end
            end
            STREAM: begin
                overrun = dump_v_i;
                if (ready_i) begin
                    handshake = 1'b1;
                    if (at_last) begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Live counters never pause; on an accepted dump with clearing, this cycle's event opens the new epoch.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < els_p; k++) begin
                live_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < els_p; k++) begin
                if (dump_accept && clear_on_dump_p) begin
                    live_r[k] <= width_p'(countme_i[k]);
                end else if (countme_i[k] && (live_r[k] != max_count_lp)) begin
                    live_r[k] <= live_r[k] + width_p'(1);
                end
            end
        end
    end

    // Snapshot excludes the dump cycle's events because it samples the pre-update live values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < els_p; k++) begin
                shadow_r[k] <= '0;
            end
        end else if (dump_accept) begin
            for (int k = 0; k < els_p; k++) begin
                shadow_r[k] <= live_r[k];
            end
        end
    end

    // Stream index restarts at every accepted dump and steps once per accepted beat.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            index_r <= '0;
        end else if (dump_accept) begin
            index_r <= '0;
        end else if (handshake && !at_last) begin
            index_r <= index_r + lg_els_lp'(1);
        end
    end

    assign v_o       = (state_r == STREAM);
    assign busy_o    = (state_r == STREAM);
    assign id_o      = index_r;
    assign count_o   = shadow_r[index_r];
    assign last_o    = v_o & at_last;
    assign overrun_o = overrun;

`ifdef BSG_NONSYNTH
    dump_is_strobe: assert property (@(posedge clk_i) disable iff (reset_i) dump_v_i |=> !dump_v_i)
        else $warning("dump_v_i held high for more than one cycle");
    valid_holds: assert property (@(posedge clk_i) disable iff (reset_i) (v_o && !ready_i) |=> v_o)
        else $error("v_o dropped without a handshake");
`endif

endmodule

// File: tb/tb_bsg_profiler_counter_bank.sv
module tb_bsg_profiler_counter_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic [3:0] countme = '0;
    logic       dump_v = 1'b0;
    logic       ready = 1'b1;

    // u0: 4 entries, 4-bit counters, clear on dump
    logic       v0, last0, busy0, ovr0;
    logic [1:0] id0;
    logic [3:0] cnt0;
    // u1: 3 entries, 5-bit counters, no clear on dump
    logic       v1, last1, busy1, ovr1;
    logic [1:0] id1;
    logic [4:0] cnt1;

    bsg_profiler_counter_bank #(.els_p(4), .width_p(4), .clear_on_dump_p(1'b1)) u0 (
        .clk_i(clk), .reset_i(rst), .countme_i(countme), .dump_v_i(dump_v),
        .v_o(v0), .ready_i(ready), .id_o(id0), .count_o(cnt0),
        .last_o(last0), .busy_o(busy0), .overrun_o(ovr0)
    );

    bsg_profiler_counter_bank #(.els_p(3), .width_p(5), .clear_on_dump_p(1'b0)) u1 (
        .clk_i(clk), .reset_i(rst), .countme_i(countme[2:0]), .dump_v_i(dump_v),
        .v_o(v1), .ready_i(ready), .id_o(id1), .count_o(cnt1),
        .last_o(last1), .busy_o(busy1), .overrun_o(ovr1)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // live: running event totals per instance; snap: last accepted snapshot;
    // rem: beats of the snapshot still to be delivered (0 = idle).
    int live [2][4];
    int snap [2][4];
    int rem  [2];

    function automatic int els_of(input int m);
        return (m == 0) ? 4 : 3;
    endfunction
    function automatic int max_of(input int m);
        return (m == 0) ? 15 : 31;
    endfunction
    function automatic bit clr_of(input int m);
        return (m == 0);
    endfunction

    always @(posedge clk or posedge rst) begin
        bit busy, acc;
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                rem[m] = 0;
                for (int k = 0; k < 4; k++) begin
                    live[m][k] = 0;
                    snap[m][k] = 0;
                end
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                busy = (rem[m] > 0);
                acc  = !busy && dump_v;
                if (busy && ready) rem[m] = rem[m] - 1;
                if (acc) begin
                    for (int k = 0; k < els_of(m); k++) snap[m][k] = live[m][k];
                    rem[m] = els_of(m);
                end
                for (int k = 0; k < els_of(m); k++) begin
                    if (acc && clr_of(m))
                        live[m][k] = int'(countme[k]);
                    else if (countme[k])
                        live[m][k] = (live[m][k] + 1 > max_of(m)) ? max_of(m) : live[m][k] + 1;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    int cap  [2][4];
    int hs   [2];
    int novr [2];
    bit pstall [2];
    int pid  [2];
    int pcnt [2];

    task automatic clear_caps();
        for (int m = 0; m < 2; m++) begin
            hs[m] = 0;
            novr[m] = 0;
            for (int k = 0; k < 4; k++) cap[m][k] = -1;
        end
    endtask

    task automatic cmp_inst(input int m, input int v, input int id, input int cnt,
                            input int last, input int busy, input int ovr);
        int exp_v;
        int idx;
        exp_v = (rem[m] > 0) ? 1 : 0;
        chk($sformatf("u%0d.v_o", m), v, exp_v);
        chk($sformatf("u%0d.busy_o", m), busy, exp_v);
        chk($sformatf("u%0d.last_o", m), last, (rem[m] == 1) ? 1 : 0);
        chk($sformatf("u%0d.overrun_o", m), ovr, (exp_v == 1 && dump_v) ? 1 : 0);
        if (exp_v == 1) begin
            idx = els_of(m) - rem[m];
            chk($sformatf("u%0d.id_o", m), id, idx);
            chk($sformatf("u%0d.count_o", m), cnt, snap[m][idx]);
        end
        if (pstall[m]) begin
            chk($sformatf("u%0d.hold_v", m), v, 1);
            chk($sformatf("u%0d.hold_id", m), id, pid[m]);
            chk($sformatf("u%0d.hold_count", m), cnt, pcnt[m]);
        end
        pstall[m] = (v == 1) && !ready;
        pid[m]    = id;
        pcnt[m]   = cnt;
        if (v == 1 && ready) begin
            hs[m]++;
            if (id < 4) cap[m][id] = cnt;
        end
        if (ovr == 1) novr[m]++;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst.u0.v_o", v0, 0);
            chk("rst.u0.busy_o", busy0, 0);
            chk("rst.u0.last_o", last0, 0);
            chk("rst.u1.v_o", v1, 0);
            chk("rst.u1.busy_o", busy1, 0);
            chk("rst.u1.last_o", last1, 0);
            pstall[0] = 1'b0;
            pstall[1] = 1'b0;
        end else begin
            cmp_inst(0, int'(v0), int'(id0), int'(cnt0), int'(last0), int'(busy0), int'(ovr0));
            cmp_inst(1, int'(v1), int'(id1), int'(cnt1), int'(last1), int'(busy1), int'(ovr1));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_dump();
        dump_v = 1'b1;
        step();
        dump_v = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy0 || busy1) && n < 64) begin
            step();
            n++;
        end
        chk("wait_idle_timeout", int'(busy0 | busy1), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_caps();
        pstall[0] = 1'b0;
        pstall[1] = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("reset.u0.v_o", v0, 0);
        chk("reset.u0.busy_o", busy0, 0);
        chk("reset.u0.overrun_o", ovr0, 0);
        chk("reset.u0.id_o", id0, 0);
        chk("reset.u1.v_o", v1, 0);
        chk("reset.u1.last_o", last1, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // basic count
        countme = 4'b0101;
        repeat (10) step();
        countme = 4'b0000;
        clear_caps();
        do_dump();
        wait_idle();
        chk("basic.u0.id0", cap[0][0], 10);
        chk("basic.u0.id1", cap[0][1], 0);
        chk("basic.u0.id2", cap[0][2], 10);
        chk("basic.u0.id3", cap[0][3], 0);
        chk("basic.u1.id2", cap[1][2], 10);
        chk("basic.u0.beats", hs[0], 4);
        clear_caps();
        do_dump();
        wait_idle();
        chk("second.u0.id0", cap[0][0], 0);
        chk("second.u0.id2", cap[0][2], 0);
        chk("second.u1.id0", cap[1][0], 10);

        // event in the dump cycle
        countme = 4'b0001;
        repeat (4) step();
        clear_caps();
        dump_v = 1'b1;
        step();
        dump_v = 1'b0;
        repeat (3) step();
        countme = 4'b0000;
        wait_idle();
        chk("samecyc.first", cap[0][0], 4);
        clear_caps();
        do_dump();
        wait_idle();
        chk("samecyc.carry", cap[0][0], 4);

        // backpressure with live traffic
        for (int i = 0; i < 8; i++) begin
            countme = 4'($urandom);
            step();
        end
        clear_caps();
        do_dump();
        for (int i = 0; i < 60 && (busy0 || busy1); i++) begin
            ready = (i % 3 == 0);
            countme = 4'($urandom);
            step();
        end
        ready = 1'b1;
        countme = 4'b0000;
        wait_idle();
        chk("bp.u0.beats", hs[0], 4);
        chk("bp.u1.beats", hs[1], 3);
        for (int k = 0; k < 4; k++) chk($sformatf("bp.u0.seen%0d", k), int'(cap[0][k] >= 0), 1);

        // overrun on the second beat
        do_dump();
        wait_idle();
        countme = 4'b0001;
        step();
        step();
        clear_caps();
        dump_v = 1'b1;
        step();
        dump_v = 1'b0;
        step();
        dump_v = 1'b1;
        step();
        dump_v = 1'b0;
        wait_idle();
        countme = 4'b0000;
        chk("ovr.u0.pulses", novr[0], 1);
        chk("ovr.u1.pulses", novr[1], 1);
        chk("ovr.u0.id0", cap[0][0], 2);
        chk("ovr.u0.id1", cap[0][1], 0);
        chk("ovr.u0.beats", hs[0], 4);
        clear_caps();
        do_dump();
        wait_idle();
        chk("ovr.next_total", cap[0][0], 5);

        // saturation
        countme = 4'b0010;
        repeat (20) step();
        countme = 4'b0000;
        clear_caps();
        do_dump();
        wait_idle();
        chk("sat.u0.id1", cap[0][1], 15);
        countme = 4'b0010;
        repeat (3) step();
        countme = 4'b0000;
        clear_caps();
        do_dump();
        wait_idle();
        chk("sat.after_clear", cap[0][1], 3);

        // reset in the middle of a stream
        countme = 4'b0111;
        do_dump();
        step();
        #2 rst = 1'b1;
        #1;
        chk("midrst.u0.v_o", v0, 0);
        chk("midrst.u0.busy_o", busy0, 0);
        chk("midrst.u0.last_o", last0, 0);
        chk("midrst.u1.v_o", v1, 0);
        chk("midrst.u1.busy_o", busy1, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        countme = 4'b0000;

        // fresh counts after reset; u1 keeps accumulating across dumps
        countme = 4'b0001;
        repeat (3) step();
        countme = 4'b0000;
        clear_caps();
        do_dump();
        wait_idle();
        chk("noclr.u1.first", cap[1][0], 3);
        chk("noclr.u0.first", cap[0][0], 3);
        countme = 4'b0001;
        repeat (3) step();
        countme = 4'b0000;
        clear_caps();
        do_dump();
        wait_idle();
        chk("noclr.u1.second", cap[1][0], 6);
        chk("noclr.u0.second", cap[0][0], 3);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            countme = 4'($urandom);
            dump_v  = ($urandom_range(0, 9) == 0);
            ready   = ($urandom_range(0, 3) != 0);
            step();
        end
        dump_v  = 1'b0;
        ready   = 1'b1;
        countme = 4'b0000;
        wait_idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
